// File: rtl/logic_unit_arbiter.sv
// Two-port round-robin arbiter in front of a shared WIDTH-bit bitwise logic unit.
// Each operation runs IDLE -> EXEC -> RESP, and the result is held until its owner accepts it.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             busy
);

    // state | meaning
    // IDLE  | arbitrate the valid requests; the winner's ready is asserted
    // EXEC  | one cycle: evaluate the latched op and register the result
    // RESP  | the owner's resp_valid is high and the result is held until resp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] f;
    logic             winner;
    logic             idle_ok;
    logic             accept;
    logic             resp_done;

    assign idle_ok = (state == IDLE) && !rst;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        winner = req1_valid;
        if (req0_valid && req1_valid)
            winner = ~last_grant;
    end

    assign req0_ready = idle_ok && req0_valid && !winner;
    assign req1_ready = idle_ok && req1_valid && winner;
    assign accept     = req0_ready || req1_ready;
    assign resp_done  = owner ? resp1_ready : resp0_ready;

    // NOR is a bitwise operation over the full width, not a logical reduction.
    always_comb begin
        f = '0;
        case (op_q)
            2'b00:   f = a_q & b_q;
            2'b01:   f = a_q | b_q;
            2'b10:   f = ~(a_q | b_q);
            default: f = a_q ^ b_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            res_data    <= '0;
            res_zero    <= 1'b1;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= winner;
                        last_grant <= winner;
                        op_q       <= winner ? req1_op : req0_op;
                        a_q        <= winner ? req1_a  : req0_a;
                        b_q        <= winner ? req1_b  : req0_b;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_data    <= f;
                    res_zero    <= (f == '0);
                    resp0_valid <= !owner;
                    resp1_valid <= owner;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: expected results are hand-computed constants.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] res_data;
    logic        res_zero, busy;

    int errors = 0;
    int checks = 0;

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .res_data(res_data), .res_zero(res_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One full transaction on port p; with drop=1 the requester scrambles its
    // operands right after the accept to show only the accepted values count.
    task automatic do_op(input string tag, input int p, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_z, input logic drop);
        set_req(p, 1'b1, op, a, b);
        #1;
        chk({tag, "_ready"}, (p == 0) ? req0_ready : req1_ready, 1);
        chk({tag, "_other_ready"}, (p == 0) ? req1_ready : req0_ready, 0);
        step();
        if (drop)
            set_req(p, 1'b0, 2'b01, 32'hDEADBEEF, 32'h0);
        chk({tag, "_exec_busy"}, busy, 1);
        chk({tag, "_exec_rv"}, {resp1_valid, resp0_valid}, 0);
        step();
        chk({tag, "_resp_rv"}, {resp1_valid, resp0_valid}, (p == 0) ? 2'b01 : 2'b10);
        chk({tag, "_data"}, res_data, exp_d);
        chk({tag, "_zero"}, res_zero, exp_z);
        if (p == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chk({tag, "_done_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        step();
        req0_valid = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        req0_valid = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_data", res_data, 32'h0);
        chk("rst_zero", res_zero, 1);
        chk("rst_rv", {resp1_valid, resp0_valid}, 0);
        rst = 1'b0;

        // Basic ops, including bitwise NOR at both extremes
        do_op("and", 0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1);
        do_op("nor0", 0, 2'b10, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        do_op("nor1", 1, 2'b10, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b1);
        do_op("xor0", 0, 2'b11, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1);
        do_op("xor1", 1, 2'b11, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b1);

        // Continuous tie after reset: grants alternate 0,1,0,1
        do_reset();
        set_req(0, 1'b1, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
        set_req(1, 1'b1, 2'b01, 32'h0000FFFF, 32'h12340000);
        do_op("rr0", 0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
        do_op("rr1", 1, 2'b01, 32'h0000FFFF, 32'h12340000, 32'h1234FFFF, 1'b0, 1'b0);
        do_op("rr2", 0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
        do_op("rr3", 1, 2'b01, 32'h0000FFFF, 32'h12340000, 32'h1234FFFF, 1'b0, 1'b1);
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Held response: port 1 waits, non-owner resp_ready ignored
        set_req(0, 1'b1, 2'b11, 32'hA5A5A5A5, 32'hFFFF0000);
        #1;
        chk("hold_accept", req0_ready, 1);
        step();
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0000FFFF);
        step();
        resp1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_data%0d", i), res_data, 32'h5A5AA5A5);
            chk($sformatf("hold_rv%0d", i), {resp1_valid, resp0_valid}, 2'b01);
            chk($sformatf("hold_r1rdy%0d", i), req1_ready, 0);
            step();
        end
        resp1_ready = 1'b0;
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        chk("hold_idle_busy", busy, 0);
        chk("hold_r1_accept", req1_ready, 1);
        step();
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("hold_p1_rv", {resp1_valid, resp0_valid}, 2'b10);
        chk("hold_p1_data", res_data, 32'h0000FFFF);
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;

        // Reset during EXEC
        set_req(0, 1'b1, 2'b01, 32'h00FF0000, 32'h000000FF);
        step();
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rexec_busy", busy, 0);
        chk("rexec_rv", {resp1_valid, resp0_valid}, 0);
        chk("rexec_data", res_data, 32'h0);
        step();
        chk("rexec_no_resp", {resp1_valid, resp0_valid}, 0);
        set_req(0, 1'b1, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b1, 2'b00, 32'h0, 32'h0);
        #1;
        chk("rexec_tie", {req1_ready, req0_ready}, 2'b01);
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);

        // Reset during RESP
        set_req(1, 1'b1, 2'b01, 32'h11110000, 32'h00002222);
        step();
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("rresp_pre_rv", {resp1_valid, resp0_valid}, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rresp_busy", busy, 0);
        chk("rresp_rv", {resp1_valid, resp0_valid}, 0);
        chk("rresp_data", res_data, 32'h0);
        chk("rresp_zero", res_zero, 1);
        set_req(0, 1'b1, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b1, 2'b00, 32'h0, 32'h0);
        #1;
        chk("rresp_tie", {req1_ready, req0_ready}, 2'b01);
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
